// File: rtl/q_update_ctrl_if.sv
// Bundle of request, configuration, Q-table RAM and updater signals around q_update_ctrl.
// act_mask is present only when Q_CTRL_MASK_EN is defined.
interface q_update_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int S_W       = 15,
  parameter int N_ACTIONS = 9,
  parameter int A_W       = 4,
  parameter int ADDR_W    = 19
);
  logic              req_valid;
  logic              req_ready;
  logic [S_W-1:0]    req_state;
  logic [A_W-1:0]    req_action;
  logic [S_W-1:0]    req_next;
  logic [DATA_W-1:0] req_reward;
  logic              req_terminal;
  logic              cfg_we;
  logic [1:0]        cfg_gamma;
  logic [1:0]        cfg_alfa;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] upd_q;
  logic [DATA_W-1:0] upd_max_q;
  logic [DATA_W-1:0] upd_reward;
  logic [1:0]        upd_gamma;
  logic [1:0]        upd_alfa;
  logic [DATA_W-1:0] upd_q_new;
  logic              busy;
  logic              done;
`ifdef Q_CTRL_MASK_EN
  logic [N_ACTIONS-1:0] act_mask;
`endif

  // Controller side
  modport slave (
`ifdef Q_CTRL_MASK_EN
    input  act_mask,
`endif
    input  req_valid, req_state, req_action, req_next, req_reward, req_terminal,
    input  cfg_we, cfg_gamma, cfg_alfa, mem_rdata, upd_q_new,
    output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output upd_q, upd_max_q, upd_reward, upd_gamma, upd_alfa, busy, done
  );

  // Agent / RAM / updater side
  modport master (
`ifdef Q_CTRL_MASK_EN
    output act_mask,
`endif
    output req_valid, req_state, req_action, req_next, req_reward, req_terminal,
    output cfg_we, cfg_gamma, cfg_alfa, mem_rdata, upd_q_new,
    input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  upd_q, upd_max_q, upd_reward, upd_gamma, upd_alfa, busy, done
  );
endinterface

// File: rtl/q_update_ctrl.sv
// Sequencer for one Q-learning update: read Q(s,a), scan Q(s',*) for the max, write Q_new back.
// Define Q_CTRL_MASK_EN to restrict the scan to the legal actions given by act_mask.
module q_update_ctrl #(
  parameter int DATA_W    = 16,
  parameter int S_W       = 15,
  parameter int N_ACTIONS = 9,
  parameter int A_W       = 4,
  parameter int ADDR_W    = 19
) (
  input  logic           clk,
  input  logic           rst,
  q_update_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_Q, SCAN, DRAIN, CALC, WR} state_t;

  state_t                      state_reg;
  logic [S_W-1:0]              s_reg;
  logic [S_W-1:0]              sn_reg;
  logic [A_W-1:0]              a_reg;
  logic [A_W-1:0]              idx_reg;
  logic [DATA_W-1:0]           r_reg;
  logic                        term_reg;
  logic [N_ACTIONS-1:0]        mask_reg;
  logic [1:0]                  cfg_gamma_reg;
  logic [1:0]                  cfg_alfa_reg;
  logic [1:0]                  gamma_snap_reg;
  logic [1:0]                  alfa_snap_reg;
  logic                        rd_pend_reg;
  logic                        q_got_reg;
  logic                        max_set_reg;
  logic signed [DATA_W-1:0]    q_reg;
  logic signed [DATA_W-1:0]    max_reg;

  logic signed [DATA_W-1:0]    q_next;
  logic signed [DATA_W-1:0]    max_next;
  logic                        max_set_next;
  logic [N_ACTIONS-1:0]        req_mask;
  logic [N_ACTIONS-1:0]        above_mask;
  logic                        first_hit;
  logic                        next_hit;
  logic [A_W-1:0]              first_idx;
  logic [A_W-1:0]              next_idx;

`ifdef Q_CTRL_MASK_EN
  assign req_mask = bus.act_mask;
`else
  assign req_mask = '1;
`endif

  function automatic logic [ADDR_W-1:0] addr_of(input logic [S_W-1:0] s, input logic [A_W-1:0] a);
    return ADDR_W'(s) * ADDR_W'(N_ACTIONS) + ADDR_W'(a);
  endfunction

  // Actions strictly after the one currently being read
  for (genvar gi = 0; gi < N_ACTIONS; gi++) begin : g_above
    assign above_mask[gi] = (gi > int'(idx_reg));
  end

  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    next_hit  = 1'b0;
    next_idx  = '0;
    for (int k = N_ACTIONS - 1; k >= 0; k--) begin
      if (mask_reg[k]) begin
        first_hit = 1'b1;
        first_idx = A_W'(k);
      end
      if (mask_reg[k] && above_mask[k]) begin
        next_hit = 1'b1;
        next_idx = A_W'(k);
      end
    end
  end

  // Data returned for the read issued last cycle: first one is Q(s,a), the rest compete for max.
  // Strict compare so that ties keep the earlier value.
  always_comb begin
    q_next       = q_reg;
    max_next     = max_reg;
    max_set_next = max_set_reg;
    if (rd_pend_reg) begin
      if (!q_got_reg) begin
        q_next = bus.mem_rdata;
      end else if (!max_set_reg || ($signed(bus.mem_rdata) > max_reg)) begin
        max_next     = bus.mem_rdata;
        max_set_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      s_reg          <= '0;
      sn_reg         <= '0;
      a_reg          <= '0;
      idx_reg        <= '0;
      r_reg          <= '0;
      term_reg       <= 1'b0;
      mask_reg       <= '0;
      cfg_gamma_reg  <= 2'b00;
      cfg_alfa_reg   <= 2'b00;
      gamma_snap_reg <= 2'b00;
      alfa_snap_reg  <= 2'b00;
      rd_pend_reg    <= 1'b0;
      q_got_reg      <= 1'b0;
      max_set_reg    <= 1'b0;
      q_reg          <= '0;
      max_reg        <= '0;
      bus.req_ready  <= 1'b0;
      bus.mem_rd_en  <= 1'b0;
      bus.mem_wr_en  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.upd_q      <= '0;
      bus.upd_max_q  <= '0;
      bus.upd_reward <= '0;
      bus.upd_gamma  <= 2'b00;
      bus.upd_alfa   <= 2'b00;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        cfg_gamma_reg <= bus.cfg_gamma;
        cfg_alfa_reg  <= bus.cfg_alfa;
      end
      rd_pend_reg <= bus.mem_rd_en;
      q_reg       <= q_next;
      max_reg     <= max_next;
      max_set_reg <= max_set_next;
      q_got_reg   <= q_got_reg | rd_pend_reg;

      case (state_reg)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            s_reg          <= bus.req_state;
            a_reg          <= bus.req_action;
            sn_reg         <= bus.req_next;
            r_reg          <= bus.req_reward;
            term_reg       <= bus.req_terminal;
            mask_reg       <= req_mask;
            gamma_snap_reg <= cfg_gamma_reg;
            alfa_snap_reg  <= cfg_alfa_reg;
            q_got_reg      <= 1'b0;
            max_set_reg    <= 1'b0;
            q_reg          <= '0;
            max_reg        <= '0;
            bus.req_ready  <= 1'b0;
            bus.busy       <= 1'b1;
            bus.mem_rd_en  <= 1'b1;
            bus.mem_addr   <= addr_of(bus.req_state, bus.req_action);
            state_reg      <= RD_Q;
          end
        end
        RD_Q: begin
          if (!term_reg && first_hit) begin
            bus.mem_addr <= addr_of(sn_reg, first_idx);
            idx_reg      <= first_idx;
            state_reg    <= SCAN;
          end else begin
            bus.mem_rd_en <= 1'b0;
            state_reg     <= DRAIN;
          end
        end
        SCAN: begin
          if (next_hit) begin
            bus.mem_addr <= addr_of(sn_reg, next_idx);
            idx_reg      <= next_idx;
          end else begin
            bus.mem_rd_en <= 1'b0;
            state_reg     <= DRAIN;
          end
        end
        DRAIN: begin
          // Nothing scanned (terminal or empty mask) means max_Q is zero
          bus.upd_q      <= q_next;
          bus.upd_max_q  <= max_set_next ? max_next : '0;
          bus.upd_reward <= r_reg;
          bus.upd_gamma  <= gamma_snap_reg;
          bus.upd_alfa   <= alfa_snap_reg;
          state_reg      <= CALC;
        end
        CALC: begin
          bus.mem_wdata <= bus.upd_q_new;
          bus.mem_wr_en <= 1'b1;
          bus.mem_addr  <= addr_of(s_reg, a_reg);
          bus.done      <= 1'b1;
          state_reg     <= WR;
        end
        WR: begin
          bus.mem_wr_en <= 1'b0;
          bus.done      <= 1'b0;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_update_ctrl.sv
// Testbench for q_update_ctrl: table vectors, reset/backpressure sequences and randomized updates
// checked against a list-based reference model of the Q-table.
module tb_q_update_ctrl;
  localparam int DW   = 16;
  localparam int SW   = 15;
  localparam int NA   = 9;
  localparam int AW   = 4;
  localparam int ADW  = 19;
  localparam int RAMN = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_update_ctrl_if #(.DATA_W(DW), .S_W(SW), .N_ACTIONS(NA), .A_W(AW), .ADDR_W(ADW)) bus ();

  q_update_ctrl #(.DATA_W(DW), .S_W(SW), .N_ACTIONS(NA), .A_W(AW), .ADDR_W(ADW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Example updater: Q + ((r + (maxQ >>> gamma) - Q) >>> alfa)
  function automatic logic [15:0] upd_fn(input logic [15:0] q, input logic [15:0] m,
                                         input logic [15:0] r, input logic [1:0] g, input logic [1:0] al);
    int qi, mi, ri, d;
    qi = int'($signed(q));
    mi = int'($signed(m));
    ri = int'($signed(r));
    d  = ri + (mi >>> g) - qi;
    return 16'(qi + (d >>> al));
  endfunction

  assign bus.upd_q_new = upd_fn(bus.upd_q, bus.upd_max_q, bus.upd_reward, bus.upd_gamma, bus.upd_alfa);

  logic [15:0] ram     [0:RAMN-1];
  logic [15:0] ref_ram [0:RAMN-1];
  bit          init_done [0:RAMN-1];
  logic        poke_en = 1'b0;
  int          poke_addr = 0;
  logic [15:0] poke_val = '0;

  int cyc = 0, acc_cnt = 0, wr_cnt = 0, rd_cnt = 0, overlap = 0, stray_done = 0;
  int wr_cyc = 0, done_at_wr = 0, w_addr = 0;
  logic [15:0] w_data = '0;
  int acc_hist[$];

  // RAM with 1-cycle read latency plus transaction monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.req_valid && bus.req_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_hist.push_back(cyc);
      rd_cnt <= 0;
    end else if (bus.mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr[11:0]];
    if (poke_en) begin
      ram[poke_addr] <= poke_val;
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
      w_addr <= int'(bus.mem_addr);
      w_data <= bus.mem_wdata;
      if (bus.done) done_at_wr <= done_at_wr + 1;
    end
    if (bus.mem_rd_en && bus.mem_wr_en) overlap <= overlap + 1;
    if (bus.done && !bus.mem_wr_en) stray_done <= stray_done + 1;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cur_g    = 0;
  int cur_al   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic poke(input int ad, input logic [15:0] v);
    poke_addr = ad;
    poke_val  = v;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_ram[ad]   = v;
    init_done[ad] = 1'b1;
  endtask

  task automatic ensure_init(input int ad);
    if (!init_done[ad]) poke(ad, 16'(int'($urandom_range(0, 2000)) - 1000));
  endtask

  task automatic set_cfg(input int g, input int al);
    bus.cfg_we    = 1'b1;
    bus.cfg_gamma = 2'(g);
    bus.cfg_alfa  = 2'(al);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    cur_g  = g;
    cur_al = al;
  endtask

  // Reference: max over the list of legal next-state values, 0 if none
  task automatic model(input int s, input int a, input int sn, input int r, input bit term,
                       input logic [8:0] mask, input int g, input int al,
                       output int eq, output int emax, output int enew,
                       output int eaddr, output int elat, output int erd);
    int n, v;
    bit found;
    eaddr = s * NA + a;
    eq    = int'($signed(ref_ram[eaddr]));
    n = 0; found = 1'b0; emax = 0;
    if (!term) begin
      for (int i = 0; i < NA; i++) begin
        if (mask[i]) begin
          v = int'($signed(ref_ram[sn * NA + i]));
          if (!found || v > emax) emax = v;
          found = 1'b1;
          n++;
        end
      end
    end
    enew = int'($signed(upd_fn(16'(eq), 16'(emax), 16'(r), 2'(g), 2'(al))));
    ref_ram[eaddr] = 16'(enew);
    elat = 4 + n;
    erd  = 1 + n;
  endtask

  task automatic run_req(input int s, input int a, input int sn, input int r, input bit term,
                         output bit ok, output int lat, output int nrd, output int ndone);
    int prev_wr, prev_dn;
    prev_wr = wr_cnt;
    prev_dn = done_at_wr;
    ok = 1'b0; lat = -1; nrd = -1; ndone = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) break;
      @(negedge clk);
    end
    bus.req_state    = SW'(s);
    bus.req_action   = AW'(a);
    bus.req_next     = SW'(sn);
    bus.req_reward   = DW'(r);
    bus.req_terminal = term;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (wr_cnt != prev_wr) break;
      @(negedge clk);
    end
    if (wr_cnt != prev_wr) begin
      ok    = 1'b1;
      lat   = wr_cyc - acc_hist[$];
      nrd   = rd_cnt;
      ndone = done_at_wr - prev_dn;
    end
  endtask

  task automatic check_txn(input string tag, input int s, input int a, input int sn, input int r,
                           input bit term, input int eq, input int emax, input int enew,
                           input int eaddr, input int elat, input int erd);
    bit ok;
    int lat, nrd, ndone;
    run_req(s, a, sn, r, term, ok, lat, nrd, ndone);
    chk({tag, "_timeout"}, int'(ok), 1);
    if (ok) begin
      chk({tag, "_addr"}, w_addr, eaddr);
      chk({tag, "_wdata"}, int'($signed(w_data)), enew);
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_reads"}, nrd, erd);
      chk({tag, "_done"}, ndone, 1);
      chk({tag, "_upd_q"}, int'($signed(bus.upd_q)), eq);
      chk({tag, "_upd_max_q"}, int'($signed(bus.upd_max_q)), emax);
      chk({tag, "_upd_reward"}, int'($signed(bus.upd_reward)), r);
      chk({tag, "_upd_gamma"}, int'(bus.upd_gamma), cur_g);
      chk({tag, "_upd_alfa"}, int'(bus.upd_alfa), cur_al);
    end
    $display("%s s=%0d a=%0d s'=%0d r=%0d term=%0d -> addr=%0d wdata=%0d lat=%0d reads=%0d",
             tag, s, a, sn, r, term, w_addr, int'($signed(w_data)), lat, nrd);
  endtask

  function automatic int outs_ones();
    return $countones({bus.req_ready, bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en,
                       bus.mem_addr, bus.mem_wdata, bus.upd_q, bus.upd_max_q,
                       bus.upd_reward, bus.upd_gamma, bus.upd_alfa});
  endfunction

  typedef struct {
    int s, a, sn, r;
    bit term;
    int g, al, eq, emax, eaddr, elat, erd;
  } vec_t;

  vec_t vecs[4];
  int   t2[NA] = '{-3, 40, 40, -1, 0, 12, 9, 8, 7};
  int   sl[NA] = '{1, 2, 3, 50, 4, 5, 6, 7, 8};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eq, emax, enew, eaddr, elat, erd, base, prev_wr, n0, g1, a1, wd1, e1, e2, gap;
    int s, a, sn, r;
    bit term;

    vecs[0] = '{5, 2, 7, 16, 1'b0, 1, 2, 100, 40, 47, 13, 10};
    vecs[1] = '{0, 4, 9, -64, 1'b1, 2, 1, 30, 0, 4, 4, 1};
    vecs[2] = '{10, 1, 11, 3, 1'b0, 0, 1, 7, -5, 91, 13, 10};
    vecs[3] = '{12, 3, 12, -8, 1'b0, 3, 0, 50, 50, 111, 13, 10};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_state = '0; bus.req_action = '0; bus.req_next = '0;
    bus.req_reward = '0; bus.req_terminal = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_gamma = '0; bus.cfg_alfa = '0;
`ifdef Q_CTRL_MASK_EN
    bus.act_mask = 9'h1FF;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_ones(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(bus.req_ready), 1);
    chk("reset_busy", int'(bus.busy), 0);

    // Table vectors
    poke(47, 16'd100);
    for (int i = 0; i < NA; i++) poke(63 + i, 16'(t2[i]));
    poke(4, 16'd30);
    poke(91, 16'd7);
    for (int i = 0; i < NA; i++) poke(99 + i, 16'(-5 - i));
    for (int i = 0; i < NA; i++) poke(108 + i, 16'(sl[i]));
    for (int i = 0; i < 4; i++) begin
      set_cfg(vecs[i].g, vecs[i].al);
      enew = int'($signed(upd_fn(16'(vecs[i].eq), 16'(vecs[i].emax), 16'(vecs[i].r),
                                 2'(vecs[i].g), 2'(vecs[i].al))));
      ref_ram[vecs[i].eaddr] = 16'(enew);
      check_txn($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].sn, vecs[i].r, vecs[i].term,
                vecs[i].eq, vecs[i].emax, enew, vecs[i].eaddr, vecs[i].elat, vecs[i].erd);
    end

`ifdef Q_CTRL_MASK_EN
    bus.act_mask = 9'b000100010;
    model(5, 2, 7, 11, 1'b0, 9'b000100010, cur_g, cur_al, eq, emax, enew, eaddr, elat, erd);
    check_txn("mask_1_5", 5, 2, 7, 11, 1'b0, eq, emax, enew, eaddr, elat, erd);
    bus.act_mask = 9'b0;
    model(5, 2, 7, 11, 1'b0, 9'b0, cur_g, cur_al, eq, emax, enew, eaddr, elat, erd);
    check_txn("mask_zero", 5, 2, 7, 11, 1'b0, eq, emax, enew, eaddr, elat, erd);
    bus.act_mask = 9'h1FF;
`endif

    // Reset in the middle of a scan
    ensure_init(20 * NA);
    for (int i = 0; i < NA; i++) ensure_init(21 * NA + i);
    base    = 20 * NA;
    prev_wr = wr_cnt;
    bus.req_state = SW'(20); bus.req_action = '0; bus.req_next = SW'(21);
    bus.req_reward = DW'(5); bus.req_terminal = 1'b0; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_outputs_zero_c%0d", i), outs_ones(), 0);
    end
    rst = 1'b0;
    cur_g = 0;
    cur_al = 0;
    @(negedge clk);
    chk("midrst_ready", int'(bus.req_ready), 1);
    repeat (12) @(negedge clk);
    chk("midrst_no_write", wr_cnt - prev_wr, 0);
    chk("midrst_ram_untouched", int'(ram[base]), int'(ref_ram[base]));
    $display("midrst s=20 a=0 s'=21 aborted, writes=%0d", wr_cnt - prev_wr);

    // Backpressure: valid held through an update, config change only affects the second one
    set_cfg(1, 1);
    ensure_init(40 * NA + 5);
    for (int i = 0; i < NA; i++) ensure_init(41 * NA + i);
    model(40, 5, 41, 77, 1'b0, 9'h1FF, 1, 1, eq, emax, e1, eaddr, elat, erd);
    model(40, 5, 41, 77, 1'b0, 9'h1FF, 2, 3, eq, emax, e2, eaddr, elat, erd);
    prev_wr = wr_cnt;
    n0      = acc_cnt;
    bus.req_state = SW'(40); bus.req_action = AW'(5); bus.req_next = SW'(41);
    bus.req_reward = DW'(77); bus.req_terminal = 1'b0; bus.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt != n0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    set_cfg(2, 3);
    for (int i = 0; i < 40; i++) begin
      if (wr_cnt != prev_wr) break;
      @(negedge clk);
    end
    g1  = int'(bus.upd_gamma);
    a1  = int'(bus.upd_alfa);
    wd1 = int'($signed(w_data));
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt == n0 + 2) break;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("bp_second_accept", acc_cnt - n0, 2);
    gap = (acc_hist.size() >= 2) ? acc_hist[$] - acc_hist[$-1] : -1;
    chk("bp_accept_gap", gap, 14);
    for (int i = 0; i < 40; i++) begin
      if (wr_cnt == prev_wr + 2) break;
      @(negedge clk);
    end
    chk("bp_writes", wr_cnt - prev_wr, 2);
    chk("bp_first_gamma", g1, 1);
    chk("bp_first_alfa", a1, 1);
    chk("bp_first_wdata", wd1, e1);
    chk("bp_second_gamma", int'(bus.upd_gamma), 2);
    chk("bp_second_alfa", int'(bus.upd_alfa), 3);
    chk("bp_second_wdata", int'($signed(w_data)), e2);
    repeat (3) @(negedge clk);
    chk("bp_no_extra_accept", acc_cnt - n0, 2);
    $display("backpressure s=40 a=5 s'=41 gap=%0d wdata1=%0d wdata2=%0d", gap, wd1, int'($signed(w_data)));

    // Randomized updates
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      s    = int'($urandom_range(0, 390));
      a    = int'($urandom_range(0, NA - 1));
      sn   = ($urandom_range(0, 4) == 0) ? s : int'($urandom_range(0, 390));
      r    = int'($urandom_range(0, 400)) - 200;
      term = ($urandom_range(0, 3) == 0);
      ensure_init(s * NA + a);
      for (int i = 0; i < NA; i++) ensure_init(sn * NA + i);
      model(s, a, sn, r, term, 9'h1FF, cur_g, cur_al, eq, emax, enew, eaddr, elat, erd);
      check_txn($sformatf("rand%0d", k), s, a, sn, r, term, eq, emax, enew, eaddr, elat, erd);
    end

    chk("rd_wr_never_overlap", overlap, 0);
    chk("done_only_with_write", stray_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
